// File: rtl/mips_mem_responder.sv
// Memory-side responder for the multicycle MIPS core: word RAM plus a small I/O region
// holding a free-running cycle counter, an LED register and a valid/ready output FIFO.
module mips_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] IO_BASE    = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wr_data,
  input  logic        mem_wr_ena,
  output logic [31:0] mem_rd_data,
  output logic [7:0]  leds,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int unsigned PtrW      = $clog2(FIFO_DEPTH);
  localparam int unsigned RamWords  = 1 << ADDR_WIDTH;
  localparam logic [3:0]  CntFull   = 4'(FIFO_DEPTH);
  localparam logic [15:0] OffCycle  = 16'h0000;
  localparam logic [15:0] OffLed    = 16'h0004;
  localparam logic [15:0] OffTx     = 16'h0008;
  localparam logic [15:0] OffStatus = 16'h000C;

  logic                  io_sel;
  logic [15:0]           offset;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic [31:0]           ram [RamWords];
  logic [31:0]           fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [3:0]            count_q, count_d;
  logic [31:0]           cycle_q;
  logic [7:0]            leds_q;
  logic                  overflow_q, overflow_d;
  logic                  full, empty, pop, push_req, push, ovf_clr;

  assign io_sel  = (mem_addr[31:16] == IO_BASE);
  assign offset  = mem_addr[15:0];
  assign ram_idx = mem_addr[ADDR_WIDTH+1:2];

  assign full     = (count_q == CntFull);
  assign empty    = (count_q == 4'd0);
  assign pop      = out_valid & out_ready;
  assign push_req = mem_wr_ena & io_sel & (offset == OffTx);
  // A pop in the same cycle frees a slot, so a push at full is still accepted.
  assign push     = push_req & (~full | pop);
  assign ovf_clr  = mem_wr_ena & io_sel & (offset == OffStatus) & mem_wr_data[2];

  assign leds      = leds_q;
  assign out_valid = ~empty;
  assign out_data  = fifo_mem[rd_ptr_q];

  // Storage arrays are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_wr_ena && !io_sel) begin
      ram[ram_idx] <= mem_wr_data;
    end
    if (push) begin
      fifo_mem[wr_ptr_q] <= mem_wr_data;
    end
  end

  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push && !pop) begin
      count_d = count_q + 4'd1;
    end else if (pop && !push) begin
      count_d = count_q - 4'd1;
    end
    if (push_req && !push) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      cycle_q    <= '0;
      leds_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      cycle_q    <= cycle_q + 32'd1;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      if (mem_wr_ena && io_sel && (offset == OffLed)) begin
        leds_q <= mem_wr_data[7:0];
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

  always_comb begin
    mem_rd_data = '0;
    if (!io_sel) begin
      mem_rd_data = ram[ram_idx];
    end else begin
      case (offset)
        OffCycle:  mem_rd_data = cycle_q;
        OffLed:    mem_rd_data = {24'b0, leds_q};
        OffStatus: mem_rd_data = {24'b0, count_q, 1'b0, overflow_q, empty, full};
        default:   mem_rd_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Bench for mips_mem_responder: directed vector table, reset/counter sequences and
// randomized traffic checked against a queue-based reference model.
module tb_mips_mem_responder;

  localparam int unsigned Depth = 4;

  logic        clk = 1'b0;
  logic        rstb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic        mem_wr_ena;
  logic [31:0] mem_rd_data;
  logic [7:0]  leds;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  int checks   = 0;
  int failures = 0;

  mips_mem_responder #(
    .ADDR_WIDTH(10),
    .FIFO_DEPTH(Depth),
    .IO_BASE   (16'hFFFF)
  ) dut (
    .clk        (clk),
    .rstb       (rstb),
    .mem_addr   (mem_addr),
    .mem_wr_data(mem_wr_data),
    .mem_wr_ena (mem_wr_ena),
    .mem_rd_data(mem_rd_data),
    .leds       (leds),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_ram [1024];
  bit          m_known [1024];
  logic [31:0] m_q [$];
  logic [7:0]  m_leds;
  bit          m_ovf;
  logic [31:0] m_cycle;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [31:0] exp_out;
    logic        we;
    logic        ready;
    logic        chk_rd;
    logic        exp_valid;
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_leds  = '0;
    m_ovf   = 1'b0;
    m_cycle = '0;
  endtask

  function automatic logic [31:0] m_status();
    logic [3:0] c;
    c = 4'(m_q.size());
    return {24'b0, c, 1'b0, m_ovf, (m_q.size() == 0), (m_q.size() == Depth)};
  endfunction

  task automatic model_read(input logic [31:0] a, output bit known, output logic [31:0] v);
    known = 1'b1;
    v     = '0;
    if (a[31:16] != 16'hFFFF) begin
      known = m_known[a[11:2]];
      v     = m_ram[a[11:2]];
    end else begin
      case (a[15:0])
        16'h0000: v = m_cycle;
        16'h0004: v = {24'b0, m_leds};
        16'h000C: v = m_status();
        default:  v = '0;
      endcase
    end
  endtask

  // Drive one cycle of core traffic, check outputs before the edge, advance the model.
  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic we,
                      input logic rdy, output logic [31:0] rd, output logic ov,
                      output logic [31:0] od);
    logic [31:0] exp;
    bit          known, io, pop, acc;
    logic [15:0] off;
    mem_addr    = a;
    mem_wr_data = d;
    mem_wr_ena  = we;
    out_ready   = rdy;
    #1;
    rd = mem_rd_data;
    ov = out_valid;
    od = out_data;
    model_read(a, known, exp);
    if (known) check($sformatf("rd_data@%08h", a), rd, exp);
    check("out_valid", {31'b0, ov}, {31'b0, (m_q.size() != 0)});
    if (m_q.size() != 0) check("out_data", od, m_q[0]);
    check("leds", {24'b0, leds}, {24'b0, m_leds});
    @(posedge clk);
    io  = (a[31:16] == 16'hFFFF);
    off = a[15:0];
    pop = (m_q.size() != 0) && rdy;
    acc = (m_q.size() < Depth) || pop;
    if (we && !io) begin
      m_ram[a[11:2]]   = d;
      m_known[a[11:2]] = 1'b1;
    end
    if (we && io && off == 16'h0004) m_leds = d[7:0];
    if (we && io && off == 16'h000C && d[2]) m_ovf = 1'b0;
    if (pop) void'(m_q.pop_front());
    if (we && io && off == 16'h0008) begin
      if (acc) m_q.push_back(d);
      else m_ovf = 1'b1;
    end
    m_cycle = m_cycle + 32'd1;
    @(negedge clk);
  endtask

  task automatic add(input logic [31:0] a, input logic [31:0] d, input logic we,
                     input logic rdy, input logic chk, input logic [31:0] erd,
                     input logic ev, input logic [31:0] eo);
    vec_t v;
    v.addr = a; v.wdata = d; v.we = we; v.ready = rdy;
    v.chk_rd = chk; v.exp_rd = erd; v.exp_valid = ev; v.exp_out = eo;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] rd, od, a, d;
    logic        ov;
    logic [15:0] offs [8];

    rstb = 1'b0; mem_addr = 32'hFFFF000C; mem_wr_data = '0; mem_wr_ena = 1'b0;
    out_ready = 1'b0;
    model_reset();
    #1;
    check("reset out_valid", {31'b0, out_valid}, 32'd0);
    check("reset leds", {24'b0, leds}, 32'd0);
    check("reset status", mem_rd_data, 32'h02);
    @(negedge clk);
    rstb = 1'b1;

    // RAM, aliasing and read-during-write
    add(32'h10, 32'hDEADBEEF, 1, 0, 0, 0, 0, 0);
    add(32'h10, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0);
    add(32'h1010, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0);
    add(32'h13, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0);
    add(32'h20, 32'h11111111, 1, 0, 0, 0, 0, 0);
    add(32'h20, 32'h22222222, 1, 0, 1, 32'h11111111, 0, 0);
    add(32'h20, 0, 0, 0, 1, 32'h22222222, 0, 0);
    // Overflow, drain, overflow clear
    for (int i = 1; i <= 5; i++) add(32'hFFFF0008, i, 1, 0, 1, 0, (i > 1), 1);
    add(32'hFFFF000C, 0, 0, 0, 1, 32'h45, 1, 1);
    add(32'hFFFF000C, 0, 0, 1, 1, 32'h45, 1, 1);
    add(32'hFFFF000C, 0, 0, 1, 1, 32'h34, 1, 2);
    add(32'hFFFF000C, 0, 0, 1, 1, 32'h24, 1, 3);
    add(32'hFFFF000C, 0, 0, 1, 1, 32'h14, 1, 4);
    add(32'hFFFF000C, 0, 0, 1, 1, 32'h06, 0, 0);
    add(32'hFFFF000C, 32'h4, 1, 0, 1, 32'h06, 0, 0);
    add(32'hFFFF000C, 0, 0, 0, 1, 32'h02, 0, 0);
    // LED and unmapped offsets
    add(32'hFFFF0004, 32'h1A5, 1, 0, 1, 0, 0, 0);
    add(32'hFFFF0004, 0, 0, 0, 1, 32'hA5, 0, 0);
    add(32'hFFFF0020, 32'hFFFFFFFF, 1, 0, 1, 0, 0, 0);
    add(32'hFFFF0020, 0, 0, 0, 1, 0, 0, 0);
    add(32'hFFFF0004, 0, 0, 0, 1, 32'hA5, 0, 0);
    add(32'hFFFF000C, 0, 0, 0, 1, 32'h02, 0, 0);
    // Push and pop together at full
    for (int i = 0; i < 4; i++) add(32'hFFFF0008, 10 + i, 1, 0, 1, 0, (i > 0), 10);
    add(32'hFFFF000C, 0, 0, 0, 1, 32'h41, 1, 10);
    add(32'hFFFF0008, 14, 1, 1, 1, 0, 1, 10);
    add(32'hFFFF000C, 0, 0, 1, 1, 32'h41, 1, 11);
    add(32'hFFFF000C, 0, 0, 1, 1, 32'h30, 1, 12);
    add(32'hFFFF000C, 0, 0, 1, 1, 32'h20, 1, 13);
    add(32'hFFFF000C, 0, 0, 1, 1, 32'h10, 1, 14);
    add(32'hFFFF000C, 0, 0, 0, 1, 32'h02, 0, 0);
    // Push and pop together at count 1
    add(32'hFFFF0008, 32'h77, 1, 0, 1, 0, 0, 0);
    add(32'hFFFF0008, 32'h88, 1, 1, 1, 0, 1, 32'h77);
    add(32'hFFFF000C, 0, 0, 1, 1, 32'h10, 1, 32'h88);
    add(32'hFFFF000C, 0, 0, 0, 1, 32'h02, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].ready, rd, ov, od);
      if (vecs[i].chk_rd) check($sformatf("vec%0d rd", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d valid", i), {31'b0, ov}, {31'b0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) check($sformatf("vec%0d out", i), od, vecs[i].exp_out);
    end

    // Cycle counter after 100 edges from reset release
    rstb = 1'b0;
    #1;
    rstb = 1'b1;
    model_reset();
    for (int i = 0; i < 100; i++) step(32'hFFFF0010, 0, 0, 0, rd, ov, od);
    step(32'hFFFF0000, 0, 0, 0, rd, ov, od);
    check("cycle after 100", rd, 32'd100);

    // Reset asserted mid-operation
    step(32'h40, 32'hCAFEF00D, 1, 0, rd, ov, od);
    for (int i = 0; i < 3; i++) step(32'hFFFF0008, 32'h500 + i, 1, 0, rd, ov, od);
    step(32'hFFFF0004, 32'h3C, 1, 0, rd, ov, od);
    step(32'hFFFF000C, 0, 0, 0, rd, ov, od);
    check("pre-reset status", rd, 32'h30);
    check("pre-reset leds", {24'b0, leds}, 32'h3C);
    mem_wr_ena = 1'b0;
    out_ready  = 1'b0;
    mem_addr   = 32'hFFFF000C;
    rstb       = 1'b0;
    #1;
    check("midrst out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst leds", {24'b0, leds}, 32'd0);
    check("midrst status", mem_rd_data, 32'h02);
    mem_addr = 32'hFFFF0000;
    #1;
    check("midrst cycle", mem_rd_data, 32'd0);
    mem_addr = 32'h40;
    #1;
    check("midrst ram", mem_rd_data, 32'hCAFEF00D);
    rstb = 1'b1;
    model_reset();
    step(32'h40, 0, 0, 0, rd, ov, od);
    check("post-reset ram", rd, 32'hCAFEF00D);

    // Randomized traffic against the model
    offs = '{16'h0000, 16'h0004, 16'h0008, 16'h0008, 16'h0008, 16'h000C, 16'h0020, 16'h0000};
    for (int i = 0; i < 600; i++) begin
      d = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        a        = $urandom;
        a[31:16] = 16'($urandom_range(0, 16'hFFFE));
        a[11:2]  = 10'($urandom_range(0, 15));
      end else begin
        a = {16'hFFFF, offs[$urandom_range(0, 7)]};
        if ($urandom_range(0, 15) == 0) a[15:0] = 16'($urandom);
      end
      step(a, d, ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) == 0), rd, ov, od);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_mem_responder.md
Name: mips_mem_responder

Overview:
- Memory-side responder for the multicycle MIPS core's single memory port (mem_addr / mem_wr_data / mem_wr_ena / mem_rd_data).
- Provides a word RAM with combinational read and clocked write.
- Provides a small memory-mapped I/O region: free-running cycle counter, LED register, and a 32-bit output FIFO drained by an external valid/ready consumer.
- Sits at top level beside the core, replacing a bare RAM model, in both simulation and synthesis.

Parameters:
ADDR_WIDTH, 10, RAM depth in words is 2**ADDR_WIDTH (byte span 4*2**ADDR_WIDTH).
FIFO_DEPTH, 4, output FIFO entries; power of two, 2..8.
IO_BASE, 16'hFFFF, mem_addr[31:16] value selecting the I/O region.

Ports:
clk  input  1  clock; all state updates on posedge.
rstb  input  1  asynchronous active-low reset.
mem_addr  input  32  byte address from the core.
mem_wr_data  input  32  write data from the core.
mem_wr_ena  input  1  write strobe; one write per cycle when high.
mem_rd_data  output  32  combinational read data for mem_addr.
leds  output  8  LED register contents.
out_data  output  32  FIFO head word (show-ahead).
out_valid  output  1  FIFO non-empty.
out_ready  input  1  consumer accepts head this cycle.

Behaviour:
- Reset (rstb low, asynchronous): cycle counter=0, leds=0, FIFO read/write pointers and count=0, overflow=0, so out_valid=0. out_data is don't-care while out_valid=0. RAM contents are not cleared. Release is taken at the next posedge.
- Decode: io_sel = (mem_addr[31:16]==IO_BASE). When io_sel is 0, the access goes to RAM at word index mem_addr[ADDR_WIDTH+1:2]. Upper address bits and mem_addr[1:0] are ignored, so addresses alias.
- RAM read: mem_rd_data = ram[index] combinationally, zero latency; the core latches it in the same cycle.
- RAM write: at posedge when mem_wr_ena=1 and io_sel=0.
- Read-during-write to the same word: mem_rd_data shows the old word until the edge, and the new word after it.
- I/O map, offset = mem_addr[15:0]:
  0x0000 CYCLE: reads the 32-bit counter. The counter increments every posedge while rstb=1 and wraps 0xFFFFFFFF to 0. Writes are ignored.
  0x0004 LED: R/W. A write stores mem_wr_data[7:0]. Reads return {24'b0, leds}.
  0x0008 TXDATA: a write pushes mem_wr_data into the FIFO. Reads return 0.
  0x000C STATUS: reads {24'b0, count[3:0], 1'b0, overflow, empty, full}.
    A write with mem_wr_data[2]=1 clears overflow; other bits are ignored.
  Any other offset: reads 0, writes ignored. I/O reads have no side effects.
- FIFO:
  - pop = out_valid & out_ready.
  - push_req = mem_wr_ena & io_sel & offset==0x0008.
  - A push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle. This includes the full case: simultaneous push and pop at full keeps count=FIFO_DEPTH.
  - A rejected push (full, no pop) drops the data, sets the sticky overflow bit, and leaves the FIFO unchanged.
  - A push to an empty FIFO makes out_valid=1 and out_data=pushed word from the next cycle (1-cycle latency).
  - Order is strict FIFO. Pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop at count=1: the old head pops, the new word becomes head, count stays 1.
  - Simultaneous overflow-clear write and a rejected push cannot occur, because there is one write per cycle.
- count holds 0..FIFO_DEPTH. full = (count==FIFO_DEPTH), empty = (count==0).
- Reset asserted mid-operation: the FIFO empties immediately and out_valid drops asynchronously; pending data is lost.

Test Plan:
- RAM read/write: write 0xDEADBEEF to 0x00000010, then read 0x00000010 and 0x00001010 (alias, ADDR_WIDTH=10) -> both return 0xDEADBEEF. Read of 0x00000013 -> same word.
- FIFO overflow: out_ready=0; write 1,2,3,4,5 to 0xFFFF0008 -> STATUS=0x45 (count 4, overflow, full). Then out_ready=1 -> out_data sequence 1,2,3,4 on consecutive cycles, then out_valid=0 and STATUS=0x06. Write 0x4 to STATUS -> STATUS=0x02.
- Push and pop at full: FIFO full with 10,11,12,13; out_ready=1 and push 14 in the same cycle -> out_data=10 that cycle, overflow stays 0, count=4, subsequent order 11,12,13,14.
- Cycle counter: release reset, wait 100 edges, read 0xFFFF0000 -> 100. Force the counter to 0xFFFFFFFF, one edge -> reads 0.
- LED and unmapped I/O: write 0x1A5 to 0xFFFF0004 -> leds=0xA5 and read returns 0x000000A5. Write to 0xFFFF0020 -> no state change; read returns 0.
- Reset mid-operation: FIFO holding 3 entries, leds=0x3C; pulse rstb low between edges -> out_valid=0, leds=0, STATUS=0x02, CYCLE=0 immediately. A RAM word written before reset still reads back its value.
